// File: rtl/filtro_iir.sv
// Biquad IIR filter: one shared multiplier, five MAC cycles per sample.
// Saturated output with a one-cycle valid strobe.
module filtro_iir #(
  parameter int cant_bits = 25,
  parameter int FRAC      = 16,
  parameter logic signed [cant_bits-1:0] B0 = cant_bits'(1) << FRAC,
  parameter logic signed [cant_bits-1:0] B1 = '0,
  parameter logic signed [cant_bits-1:0] B2 = '0,
  parameter logic signed [cant_bits-1:0] A1 = '0,
  parameter logic signed [cant_bits-1:0] A2 = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [cant_bits-1:0] dato_in,
  input  logic                 en,
  output logic [cant_bits-1:0] dato_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int W  = cant_bits;
  localparam int AW = 2 * cant_bits + 3;
  localparam logic signed [AW-1:0] MAXV =
    {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [2:0]            k;
  logic signed [W-1:0]   x, x1, x2, y1, y2;
  logic signed [W-1:0]   coef, opnd;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_ext, acc, shifted;
  logic signed [W-1:0]   y_sat;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = MAC;
      MAC:     if (k == 3'd4) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // tap select: k = 0..4 -> B0*x, B1*x1, B2*x2, A1*y1, A2*y2
  always_comb begin
    coef = '0;
    opnd = '0;
    case (k)
      3'd0: begin coef = B0; opnd = x;  end
      3'd1: begin coef = B1; opnd = x1; end
      3'd2: begin coef = B2; opnd = x2; end
      3'd3: begin coef = A1; opnd = y1; end
      3'd4: begin coef = A2; opnd = y2; end
      default: begin coef = '0; opnd = '0; end
    endcase
  end

  assign prod     = coef * opnd;
  assign prod_ext = {{3{prod[2*W-1]}}, prod};
  assign shifted  = acc >>> FRAC;

  always_comb begin
    if (shifted > MAXV)      y_sat = MAXV[W-1:0];
    else if (shifted < MINV) y_sat = MINV[W-1:0];
    else                     y_sat = shifted[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      x        <= '0;
      x1       <= '0;
      x2       <= '0;
      y1       <= '0;
      y2       <= '0;
      acc      <= '0;
      dato_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            x   <= dato_in;
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          // feedback taps are subtracted
          if (k >= 3'd3) acc <= acc - prod_ext;
          else           acc <= acc + prod_ext;
          k <= k + 3'd1;
        end
        DONE: begin
          dato_out <= y_sat;
          valid    <= 1'b1;
          x2       <= x1;
          x1       <= x;
          y2       <= y1;
          y1       <= y_sat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     overrun <= 1'b0;
    else if (en && state != IDLE) overrun <= 1'b1;
  end

endmodule
